load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit. It decodes the core's memory request, checks
//   alignment and size, runs one request/ready transaction on a simple memory
//   bus, and returns the aligned, sign- or zero-extended load result.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   mem_read, mem_write    access request from the current instruction
//   funct3                 access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   addr, wdata            effective address and store data (rs2)
//   rdata_out              load result, nonzero only in DONE of a load
//   stall                  holds the core PC and pipeline while high
//   misalign               access fault, reported in IDLE only
//   bus_req/we/addr/wdata/be, bus_ready, bus_rdata   memory handshake
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_out,
    output logic             stall,
    output logic             misalign,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [3:0]       bus_be,
    input  logic             bus_ready,
    input  logic [WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;

    logic             req;
    logic             is_write;
    logic             fault;
    logic [3:0]       be_new;
    logic [WIDTH-1:0] wdata_new;
    logic             stall_c;
    logic             misalign_c;

    // Select the addressed lane of a bus word and extend it to 32 bits.
    function automatic logic [WIDTH-1:0] load_extract(input logic [2:0]       f3,
                                                      input logic [1:0]       off,
                                                      input logic [WIDTH-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = d;
        endcase
    endfunction

    assign req      = mem_read | mem_write;
    // A simultaneous read and write is treated as a write.
    assign is_write = mem_write;

    always_comb begin
        fault     = 1'b0;
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (funct3)
            3'b000, 3'b100: begin
                fault     = is_write && funct3[2];
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                fault     = addr[0] || (is_write && funct3[2]);
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            3'b010: begin
                fault = (addr[1:0] != 2'b00);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        be_d       = be_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (fault) begin
                        misalign_c = 1'b1;
                    end else begin
                        // Stall in the request cycle so the core holds the instruction.
                        stall_c  = 1'b1;
                        addr_d   = {addr[WIDTH-1:2], 2'b00};
                        wdata_d  = wdata_new;
                        be_d     = be_new;
                        we_d     = is_write;
                        funct3_d = funct3;
                        off_d    = addr[1:0];
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (bus_ready) begin
                    rdata_d = we_q ? '0 : load_extract(funct3_q, off_q, bus_rdata);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= 4'b0000;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
        end
    end

    // Request-driven outputs are combinational from the inputs, so they are
    // masked by rst_n to stay quiet while reset is held.
    assign stall     = stall_c & rst_n;
    assign misalign  = misalign_c & rst_n;
    assign bus_req   = (state_q == BUSY);
    assign bus_we    = (state_q == BUSY) & we_q;
    assign bus_be    = (state_q == BUSY) ? be_q : 4'b0000;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata_out = ((state_q == DONE) && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. Inputs change 1 ns after a rising
// edge; outputs are sampled 4 ns after a rising edge (before the falling edge).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_out;
    logic        stall, misalign;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
        .stall(stall), .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
        #12;
        tests++;
        if ({stall, misalign, bus_req, bus_we} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000", {stall, misalign, bus_req, bus_we});
        end
        tests++;
        if ({bus_be, bus_addr, bus_wdata, rdata_out} !== 100'd0) begin
            fails++; $display("FAIL reset_data: be=%b addr=%h wdata=%h rdata=%h want all 0",
                              bus_be, bus_addr, bus_wdata, rdata_out);
        end
        mem_read = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int stall_cnt = 0;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
        #3;
        if (stall) stall_cnt++;
        tests++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            fails++; $display("FAIL lw_idle: stall=%b bus_req=%b want 1 0", stall, bus_req);
        end
        @(posedge clk); #1;
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        #3;
        if (stall) stall_cnt++;
        tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_be !== 4'b1111 || bus_we !== 1'b0) begin
            fails++; $display("FAIL lw_busy: req=%b addr=%h be=%b we=%b want 1 00000100 1111 0",
                              bus_req, bus_addr, bus_be, bus_we);
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; mem_read = 1'b0;
        #3;
        if (stall) stall_cnt++;
        tests++;
        if (rdata_out !== 32'hDEADBEEF || stall !== 1'b0 || bus_req !== 1'b0) begin
            fails++; $display("FAIL lw_done: rdata=%h stall=%b req=%b want deadbeef 0 0",
                              rdata_out, stall, bus_req);
        end
        tests++;
        if (stall_cnt !== 2) begin
            fails++; $display("FAIL lw_stall_cycles: got %0d want 2", stall_cnt);
        end
        @(posedge clk); #1;
        #3;
        tests++;
        if (rdata_out !== 32'h0) begin
            fails++; $display("FAIL lw_after_done: rdata=%h want 0", rdata_out);
        end
        #2;
    endtask

    task automatic test_load_ext();
        logic [31:0] t_addr [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [2:0]  t_f3   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] t_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            mem_read = 1'b1; funct3 = t_f3[i]; addr = t_addr[i];
            @(posedge clk); #1;
            bus_ready = 1'b1; bus_rdata = 32'h80FF1234;
            @(posedge clk); #1;
            bus_ready = 1'b0; mem_read = 1'b0;
            #3;
            tests++;
            if (rdata_out !== t_exp[i]) begin
                fails++; $display("FAIL load_ext[%0d] f3=%b: rdata=%h want %h", i, t_f3[i], rdata_out, t_exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stores();
        logic        t_rd [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  t_f3 [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] t_a  [3] = '{32'h22, 32'h41, 32'h40};
        logic [31:0] t_wd [3] = '{32'h0000ABCD, 32'h1234565A, 32'h12345678};
        logic [31:0] t_ba [3] = '{32'h20, 32'h40, 32'h40};
        logic [3:0]  t_be [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] t_bw [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h12345678};
        for (int i = 0; i < 3; i++) begin
            mem_write = 1'b1; mem_read = t_rd[i]; funct3 = t_f3[i]; addr = t_a[i]; wdata = t_wd[i];
            @(posedge clk); #1;
            bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
            #3;
            tests++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== t_ba[i] ||
                bus_be !== t_be[i] || bus_wdata !== t_bw[i]) begin
                fails++; $display("FAIL store[%0d]: req=%b we=%b addr=%h be=%b wdata=%h want 1 1 %h %b %h",
                                  i, bus_req, bus_we, bus_addr, bus_be, bus_wdata, t_ba[i], t_be[i], t_bw[i]);
            end
            @(posedge clk); #1;
            bus_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
            #3;
            tests++;
            if (rdata_out !== 32'h0 || stall !== 1'b0) begin
                fails++; $display("FAIL store_done[%0d]: rdata=%h stall=%b want 0 0", i, rdata_out, stall);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_states();
        int stall_cnt = 0;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
        #3;
        if (stall) stall_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus_ready = (i == 3); bus_rdata = 32'h0BADF00D;
            #3;
            if (stall) stall_cnt++;
            tests++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_be !== 4'b1111 || bus_we !== 1'b0) begin
                fails++; $display("FAIL wait_busy[%0d]: req=%b addr=%h be=%b we=%b want 1 00000200 1111 0",
                                  i, bus_req, bus_addr, bus_be, bus_we);
            end
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; mem_read = 1'b0;
        #3;
        if (stall) stall_cnt++;
        tests++;
        if (rdata_out !== 32'h0BADF00D || stall_cnt !== 5) begin
            fails++; $display("FAIL wait_done: rdata=%h stall_cycles=%0d want 0badf00d 5", rdata_out, stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        logic        t_wr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  t_f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
        logic [31:0] t_a  [5] = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h102};
        for (int i = 0; i < 5; i++) begin
            mem_read = ~t_wr[i]; mem_write = t_wr[i]; funct3 = t_f3[i]; addr = t_a[i];
            #3;
            tests++;
            if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
                fails++; $display("FAIL misalign[%0d]: misalign=%b stall=%b req=%b want 1 0 0",
                                  i, misalign, stall, bus_req);
            end
            @(posedge clk); #1;
            #3;
            tests++;
            if (bus_req !== 1'b0 || rdata_out !== 32'h0) begin
                fails++; $display("FAIL misalign_next[%0d]: req=%b rdata=%h want 0 0", i, bus_req, rdata_out);
            end
            mem_read = 1'b0; mem_write = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (misalign !== 1'b0) begin
            fails++; $display("FAIL misalign_clear: got %b want 0", misalign);
        end
    endtask

    task automatic test_mid_reset();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        #1;
        tests++;
        if (bus_req !== 1'b1) begin
            fails++; $display("FAIL midrst_busy: req=%b want 1", bus_req);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL midrst_drop: req=%b stall=%b want 0 0", bus_req, stall);
        end
        mem_read = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h104;
        @(posedge clk); #1;
        bus_ready = 1'b1; bus_rdata = 32'h11223344;
        #3;
        tests++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h104) begin
            fails++; $display("FAIL midrst_lw_busy: req=%b addr=%h want 1 00000104", bus_req, bus_addr);
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; mem_read = 1'b0;
        #3;
        tests++;
        if (rdata_out !== 32'h11223344 || stall !== 1'b0) begin
            fails++; $display("FAIL midrst_lw_done: rdata=%h stall=%b want 11223344 0", rdata_out, stall);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_stores();
        test_wait_states();
        test_misalign();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
